// File: rtl/temporizador_regressivo.sv
// temporizador_regressivo: loadable down-counter/timer bounded by M.
//
// Loads a duration (clamped to M-1), starts, pauses and resumes a countdown,
// and signals expiry with a one-cycle registered pulse (fim) and a level
// (pronto). Used for timeouts in FSM-based controllers.
//
// Optional feature: define AUTO_RECARGA_EN for periodic mode. The running
// count reloads from carga instead of expiring, giving a fim tick every carga
// enabled cycles. Without the macro the timer is one-shot.
//
// Parameters:
//   M : largest legal duration + 1 (loads are clamped to M-1)
//   N : width of valor/Q, must satisfy M-1 < 2**N
//
// Ports:
//   clock   in      system clock, rising edge
//   zera_n  in      synchronous active-low reset
//   carrega in      load valor into carga and Q, abort any run
//   valor   in  [N] duration in conta-enabled cycles
//   inicia  in      start (idle/expired) or resume (paused)
//   pausa   in      freeze the count while running
//   conta   in      count enable, one decrement per enabled edge
//   Q       out [N] remaining count (registered)
//   fim     out     one-cycle pulse on the edge Q reaches 0
//   meio    out     running/paused with Q == carga>>1 and carga >= 2
//   pronto  out     high while expired
//   ocupado out     high while running or paused
module temporizador_regressivo #(
  parameter int unsigned M = 5001,
  parameter int unsigned N = 13
) (
  input  logic         clock,
  input  logic         zera_n,
  input  logic         carrega,
  input  logic [N-1:0] valor,
  input  logic         inicia,
  input  logic         pausa,
  input  logic         conta,
  output logic [N-1:0] Q,
  output logic         fim,
  output logic         meio,
  output logic         pronto,
  output logic         ocupado
);

  localparam logic [N-1:0] MaxCarga = N'(M - 1);
  localparam logic [N-1:0] One      = N'(1);
  localparam logic [N-1:0] Two      = N'(2);

  typedef enum logic [1:0] {
    StInativo,
    StContando,
    StPausado,
    StFim
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] carga_q, carga_d;
  logic         fim_q, fim_d;
  logic [N-1:0] valor_sat;

  assign valor_sat = (valor > MaxCarga) ? MaxCarga : valor;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    carga_d = carga_q;
    fim_d   = 1'b0;

    if (carrega) begin
      carga_d = valor_sat;
      q_d     = valor_sat;
      state_d = StInativo;
    end else begin
      unique case (state_q)
        StInativo: begin
          // pausa outranks inicia, so a simultaneous request does nothing
          if (inicia && !pausa) begin
            if (q_q == '0) begin
              state_d = StFim;
              fim_d   = 1'b1;
            end else begin
              state_d = StContando;
            end
          end
        end
        StContando: begin
          if (pausa) begin
            state_d = StPausado;
          end else if (conta) begin
            if (q_q > One) begin
              q_d = q_q - One;
            end else if (q_q == One) begin
`ifdef AUTO_RECARGA_EN
              q_d     = carga_q;
`else
              q_d     = '0;
              state_d = StFim;
`endif
              fim_d   = 1'b1;
            end
          end
        end
        StPausado: begin
          if (inicia && !pausa) begin
            state_d = StContando;
          end
        end
        StFim: begin
          if (inicia && !pausa) begin
            q_d = carga_q;
            // A zero-length rerun expires immediately instead of stalling at Q=0
            if (carga_q != '0) begin
              state_d = StContando;
            end else begin
              fim_d = 1'b1;
            end
          end
        end
        default: state_d = StInativo;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!zera_n) begin
      state_q <= StInativo;
      q_q     <= '0;
      carga_q <= '0;
      fim_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      carga_q <= carga_d;
      fim_q   <= fim_d;
    end
  end

  assign Q       = q_q;
  assign fim     = fim_q;
  assign pronto  = (state_q == StFim);
  assign ocupado = (state_q == StContando) || (state_q == StPausado);
  assign meio    = ocupado && (carga_q >= Two) && (q_q == (carga_q >> 1));

endmodule

// File: tb/tb_temporizador_regressivo.sv
module tb_temporizador_regressivo;

  localparam int unsigned M = 5001;
  localparam int unsigned N = 13;

  logic         clock = 1'b0;
  logic         zera_n, carrega, inicia, pausa, conta;
  logic [N-1:0] valor;
  logic [N-1:0] Q;
  logic         fim, meio, pronto, ocupado;

  int checks = 0;
  int fails  = 0;

  // Reference model: duration, remaining cycles and activity flags
  int dur  = 0;
  int rem  = 0;
  bit run  = 0;  // a countdown is in progress (possibly paused)
  bit hold = 0;  // the countdown is paused
  bit done = 0;  // the countdown has expired
  bit tick = 0;  // expiry happened on the last edge

  temporizador_regressivo #(.M(M), .N(N)) dut (
    .clock  (clock),
    .zera_n (zera_n),
    .carrega(carrega),
    .valor  (valor),
    .inicia (inicia),
    .pausa  (pausa),
    .conta  (conta),
    .Q      (Q),
    .fim    (fim),
    .meio   (meio),
    .pronto (pronto),
    .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  function automatic void check(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endfunction

  function automatic void model_edge(input bit zn, input bit ld, input bit ini,
                                     input bit pa, input bit co, input int v);
    tick = 0;
    if (!zn) begin
      dur = 0; rem = 0; run = 0; hold = 0; done = 0;
    end else if (ld) begin
      dur  = (v > int'(M - 1)) ? int'(M - 1) : v;
      rem  = dur;
      run  = 0; hold = 0; done = 0;
    end else if (run && !hold) begin
      if (pa) begin
        hold = 1;
      end else if (co && rem > 0) begin
        rem = rem - 1;
        if (rem == 0) begin
          tick = 1;
`ifdef AUTO_RECARGA_EN
          rem = dur;
`else
          run  = 0;
          done = 1;
`endif
        end
      end
    end else if (run && hold) begin
      if (ini && !pa) hold = 0;
    end else if (ini && !pa) begin
      if (done) rem = dur;
      if (rem == 0) begin
        done = 1;
        tick = 1;
      end else begin
        run  = 1;
        done = 0;
      end
    end
  endfunction

  function automatic void check_all(input string tag);
    check({tag, ".Q"}, 32'(Q), 32'(rem));
    check({tag, ".fim"}, 32'(fim), 32'(tick));
    check({tag, ".pronto"}, 32'(pronto), 32'(done));
    check({tag, ".ocupado"}, 32'(ocupado), 32'(run));
    check({tag, ".meio"}, 32'(meio), 32'(run && dur >= 2 && rem == dur / 2));
  endfunction

  task automatic step(input bit zn, input bit ld, input bit ini, input bit pa,
                      input bit co, input int v, input string tag);
    zera_n  = zn;
    carrega = ld;
    inicia  = ini;
    pausa   = pa;
    conta   = co;
    valor   = N'(v);
    @(posedge clock);
    model_edge(zn, ld, ini, pa, co, v % (1 << N));
    #1;
    check_all(tag);
  endtask

  initial begin
    zera_n = 1'b0; carrega = 1'b0; inicia = 1'b0; pausa = 1'b0; conta = 1'b0;
    valor  = '0;

    // Reset
    step(0, 0, 0, 0, 0, 0, "rst");
    step(0, 1, 1, 0, 1, 7, "rst_over");
    check("rst_q", 32'(Q), 0);
    check("rst_ocupado", 32'(ocupado), 0);

    // Load 10, start, count to expiry
    step(1, 1, 0, 0, 0, 10, "ld10");
    step(1, 0, 1, 0, 1, 0, "ini10");
    check("ini_no_dec", 32'(Q), 10);
    for (int k = 1; k <= 10; k++) step(1, 0, 0, 0, 1, 0, "run10");
    check("fim_lat", 32'(fim), 1);
    step(1, 0, 0, 0, 1, 0, "after10");
    check("fim_one", 32'(fim), 0);
`ifndef AUTO_RECARGA_EN
    check("pronto10", 32'(pronto), 1);
`endif

    // Pause and resume
    step(1, 1, 0, 0, 0, 10, "ldp");
    step(1, 0, 1, 0, 0, 0, "inip");
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 1, 0, "runp");
    for (int k = 0; k < 5; k++) step(1, 0, 0, 1, 1, 0, "paused");
    check("pause_q", 32'(Q), 7);
    step(1, 0, 1, 0, 1, 0, "resume");
    check("resume_q", 32'(Q), 7);
    for (int k = 0; k < 7; k++) step(1, 0, 0, 0, 1, 0, "runr");
    check("fim_resume", 32'(fim), 1);

    // Clamp and zero-length run
    step(1, 1, 0, 0, 0, 6000, "clamp");
    check("clamp_q", 32'(Q), 5000);
    step(1, 1, 0, 0, 0, 0, "ld0");
    step(1, 0, 1, 0, 1, 0, "ini0");
    check("zero_fim", 32'(fim), 1);
    check("zero_q", 32'(Q), 0);

    // Reset and reload mid-run
    step(1, 1, 0, 0, 0, 8, "ld8");
    step(1, 0, 1, 0, 0, 0, "ini8");
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 1, 0, "run8");
    check("mid_q", 32'(Q), 4);
    step(0, 0, 0, 0, 1, 0, "midrst");
    check("midrst_q", 32'(Q), 0);
    step(1, 1, 0, 0, 0, 8, "ld8b");
    step(1, 0, 1, 0, 0, 0, "ini8b");
    for (int k = 0; k < 2; k++) step(1, 0, 0, 0, 1, 0, "run8b");
    step(1, 1, 0, 0, 1, 3, "reload3");
    check("reload_q", 32'(Q), 3);
    check("reload_ocupado", 32'(ocupado), 0);

    // Gated counting
    step(1, 1, 0, 0, 0, 4, "ld4");
    step(1, 0, 1, 0, 0, 0, "ini4");
    for (int k = 0; k < 8; k++) step(1, 0, 0, 0, k % 2, 0, "gated");
    check("gated_fim", 32'(fim), 1);

    // Random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      int v;
      v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8191))
                                      : int'($urandom_range(0, 12));
      step($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, v, "rand");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
